// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard control bus: decode-side status in, register enables/flushes out
interface hazard_ctrl_if;
  logic [3:0]  id_rs;
  logic [3:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_lw;
  logic [3:0]  ex_rd;
  logic        ex_br_taken;
  logic        mem_access;
  logic        wb_hlt;
  logic        pc_wen;
  logic        ifid_wen;
  logic        idex_wen;
  logic        exmem_wen;
  logic        memwb_wen;
  logic        ifid_flush;
  logic        idex_flush;
  logic        halted;
  logic [15:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_lw, ex_rd, ex_br_taken, mem_access, wb_hlt,
    input  pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, halted, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_lw, ex_rd, ex_br_taken, mem_access, wb_hlt,
    output pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/halt control with multi-cycle memory freeze
module hazard_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        halted_q;
  logic [15:0] stall_q;
  logic        load_use;
  logic        freeze_start;
  logic        hold;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = bus.ex_lw && (bus.ex_rd != 4'd0) &&
                    ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

  assign freeze_start = (MEM_LAT > 1) && (state == RUN) && bus.mem_access;
  assign hold         = (state == MEM_WAIT) && (cnt > 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (bus.wb_hlt) begin
          state_nxt = HALTED;
        end else if (freeze_start) begin
          state_nxt = MEM_WAIT;
          cnt_nxt   = WAIT_INIT;
        end
      end
      MEM_WAIT: begin
        if (bus.wb_hlt) begin
          state_nxt = HALTED;
          cnt_nxt   = 4'd0;
        end else if (cnt > 4'd1) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = HALTED;
      end
    endcase
  end

  // The release cycle of MEM_WAIT falls through to branch/load-use handling,
  // which is where a branch held in the frozen EX stage finally gets flushed.
  always_comb begin
    bus.pc_wen     = 1'b1;
    bus.ifid_wen   = 1'b1;
    bus.idex_wen   = 1'b1;
    bus.exmem_wen  = 1'b1;
    bus.memwb_wen  = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    if ((state == HALTED) || bus.wb_hlt || freeze_start || hold) begin
      bus.pc_wen    = 1'b0;
      bus.ifid_wen  = 1'b0;
      bus.idex_wen  = 1'b0;
      bus.exmem_wen = 1'b0;
      bus.memwb_wen = 1'b0;
    end else if (bus.ex_br_taken) begin
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_wen     = 1'b0;
      bus.ifid_wen   = 1'b0;
      bus.idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
      stall_q  <= 16'd0;
    end else begin
      halted_q <= (state_nxt == HALTED);
      if ((state != HALTED) && !bus.pc_wen && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign bus.halted    = halted_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl at MEM_LAT 1, 2 and 3
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // {halted, pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [7:0] IDLE   = 8'b0_11111_00;
  localparam logic [7:0] FROZEN = 8'b0_00000_00;
  localparam logic [7:0] LU     = 8'b0_00111_01;
  localparam logic [7:0] BR     = 8'b0_11111_11;
  localparam logic [7:0] HALT   = 8'b1_00000_00;

  logic [3:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_lw, ex_br_taken, mem_access, wb_hlt;

  hazard_ctrl_if i1 ();
  hazard_ctrl_if i2 ();
  hazard_ctrl_if i3 ();

  hazard_ctrl #(.MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  hazard_ctrl #(.MEM_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(i2));
  hazard_ctrl #(.MEM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(i3));

  assign {i1.id_rs, i2.id_rs, i3.id_rs}                   = {3{id_rs}};
  assign {i1.id_rt, i2.id_rt, i3.id_rt}                   = {3{id_rt}};
  assign {i1.id_uses_rs, i2.id_uses_rs, i3.id_uses_rs}    = {3{id_uses_rs}};
  assign {i1.id_uses_rt, i2.id_uses_rt, i3.id_uses_rt}    = {3{id_uses_rt}};
  assign {i1.ex_lw, i2.ex_lw, i3.ex_lw}                   = {3{ex_lw}};
  assign {i1.ex_rd, i2.ex_rd, i3.ex_rd}                   = {3{ex_rd}};
  assign {i1.ex_br_taken, i2.ex_br_taken, i3.ex_br_taken} = {3{ex_br_taken}};
  assign {i1.mem_access, i2.mem_access, i3.mem_access}    = {3{mem_access}};
  assign {i1.wb_hlt, i2.wb_hlt, i3.wb_hlt}                = {3{wb_hlt}};

  int errors = 0;
  int checks = 0;

  int          q_unit[$];
  string       q_tag[$];
  logic [23:0] q_exp[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] observe(input int u);
    case (u)
      1: return {i1.halted, i1.pc_wen, i1.ifid_wen, i1.idex_wen, i1.exmem_wen, i1.memwb_wen,
                 i1.ifid_flush, i1.idex_flush, i1.stall_cnt};
      2: return {i2.halted, i2.pc_wen, i2.ifid_wen, i2.idex_wen, i2.exmem_wen, i2.memwb_wen,
                 i2.ifid_flush, i2.idex_flush, i2.stall_cnt};
      default: return {i3.halted, i3.pc_wen, i3.ifid_wen, i3.idex_wen, i3.exmem_wen, i3.memwb_wen,
                       i3.ifid_flush, i3.idex_flush, i3.stall_cnt};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      int          u;
      string       t;
      logic [23:0] e, o;
      u = q_unit.pop_front();
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      o = observe(u);
      check_val({t, "_ctrl"}, {8'h00, o[23:16]}, {8'h00, e[23:16]});
      check_val({t, "_cnt"}, o[15:0], e[15:0]);
    end
  end

  task automatic expect_out(input int u, input string tag, input logic [7:0] ctrl, input logic [15:0] sc);
    q_unit.push_back(u);
    q_tag.push_back(tag);
    q_exp.push_back({ctrl, sc});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] rs, input logic [3:0] rt, input logic urs, input logic urt,
                        input logic lw, input logic [3:0] rd, input logic br, input logic mem,
                        input logic hlt);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_lw = lw; ex_rd = rd; ex_br_taken = br; mem_access = mem; wb_hlt = hlt;
  endtask

  task automatic idle();
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    idle();
    step();
    rst = 1'b1;
  endtask

  initial begin
    idle();
    #2;
    expect_out(1, "rst_u1", IDLE, 16'd0);
    expect_out(2, "rst_u2", IDLE, 16'd0);
    expect_out(3, "rst_u3", IDLE, 16'd0);
    step();
    rst = 1'b1;

    // load-use on rs/rt, gated by uses_* and register 0, overridden by branch
    step(); set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0); expect_out(1, "lu_rs", LU, 16'd0);
    step(); idle();                                                        expect_out(1, "lu_after", IDLE, 16'd1);
    step(); set_in(4'd5, 4'd3, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0); expect_out(1, "lu_rt", LU, 16'd1);
    step(); set_in(4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0); expect_out(1, "lu_unused", IDLE, 16'd2);
    step(); set_in(4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); expect_out(1, "lu_r0", IDLE, 16'd2);
    step(); set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0); expect_out(1, "br_vs_lu", BR, 16'd2);
    step(); idle();                                                        expect_out(1, "br_after", IDLE, 16'd2);

    // memory freeze, MEM_LAT = 3
    do_reset();
    step(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); expect_out(3, "frz_c1", FROZEN, 16'd0);
    step(); expect_out(3, "frz_c2", FROZEN, 16'd1);
    step(); expect_out(3, "frz_rel", IDLE, 16'd2);
    step(); idle(); expect_out(3, "frz_done", IDLE, 16'd2);

    // MEM_LAT = 1 never freezes
    do_reset();
    step(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); expect_out(1, "lat1_c1", IDLE, 16'd0);
    step(); expect_out(1, "lat1_c2", IDLE, 16'd0);

    // branch held across a freeze, MEM_LAT = 2
    do_reset();
    step(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0); expect_out(2, "brfrz_c1", FROZEN, 16'd0);
    step(); expect_out(2, "brfrz_c2", BR, 16'd1);
    step(); idle(); expect_out(2, "brfrz_done", IDLE, 16'd1);

    // halt arriving during MEM_WAIT, then async reset out of HALTED
    do_reset();
    step(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); expect_out(3, "hlt_frz", FROZEN, 16'd0);
    step(); set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 4) set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
      else idle();
      expect_out(3, "halted", HALT, 16'd2);
    end
    step(); rst = 1'b0; idle(); expect_out(3, "hlt_rst", IDLE, 16'd0);
    step(); rst = 1'b1;         expect_out(3, "hlt_run", IDLE, 16'd0);

    // saturation of stall_cnt
    do_reset();
    step(); set_in(4'd7, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 70000; k++) step();
    expect_out(1, "sat", LU, 16'hFFFF);
    step(); expect_out(1, "sat_hold", LU, 16'hFFFF);
    step(); idle(); expect_out(1, "sat_idle", IDLE, 16'hFFFF);

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
